// File: rtl/i3c_pkg.sv
// Shared types and helpers for the I3C controller's per-target table memories.
package i3c_pkg;

    localparam int TableDepth           = 128;
    localparam int TableWidth           = 64;
    localparam int TableDataBitsPerMask = 32;
    localparam int TableAw              = (TableDepth > 1) ? $clog2(TableDepth) : 1;
    localparam int TableMw              = TableWidth / TableDataBitsPerMask;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } TableInitState;

    typedef struct packed {
        logic                  write;
        logic [TableAw-1:0]    addr;
        logic [TableWidth-1:0] wdata;
        logic [TableMw-1:0]    wmask;
    } i3c_table_req_t;

    // Entry index width; a one-bit index is kept even for trivially small tables.
    function automatic int table_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/i3c_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer moves past each winner.
module i3c_rr_arbiter #(
    parameter int NumReq = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o
);

    localparam int Pw = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [Pw-1:0]     ptr_reg;
    logic [Pw-1:0]     ptr_next;
    logic [Pw-1:0]     win_idx;
    logic [NumReq-1:0] at_or_after;
    logic [NumReq-1:0] masked_req;
    logic [NumReq-1:0] pick;
    logic [NumReq-1:0] gnt_next;

    // Requests at or above the pointer win first; otherwise wrap to the lowest.
    assign at_or_after = {NumReq{1'b1}} << ptr_reg;

    always_comb begin
        masked_req = req_i & at_or_after;
        pick       = (|masked_req) ? masked_req : req_i;
        gnt_next   = '0;
        win_idx    = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (pick[i]) begin
                gnt_next    = '0;
                gnt_next[i] = 1'b1;
                win_idx     = Pw'(i);
            end
        end
        ptr_next = (win_idx == Pw'(NumReq - 1)) ? '0 : win_idx + 1'b1;
        gnt_o    = en_i ? gnt_next : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_reg <= '0;
        end else if (en_i && (|req_i)) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/i3c_table_ram.sv
// Multi-requester table memory with clear-on-reset, software clear,
// round-robin access and out-of-range detection.
module i3c_table_ram
    import i3c_pkg::*;
#(
    parameter int  Depth           = TableDepth,
    parameter int  Width           = TableWidth,
    parameter int  DataBitsPerMask = TableDataBitsPerMask,
    parameter int  NumReq          = 2,
    parameter int  OutputReg       = 0,
    localparam int Aw              = table_addr_width(Depth),
    localparam int Mw              = Width / DataBitsPerMask
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumReq-1:0]        req_i,
    output logic [NumReq-1:0]        gnt_o,
    input  logic [NumReq-1:0]        write_i,
    input  logic [NumReq*Aw-1:0]     addr_i,
    input  logic [NumReq*Width-1:0]  wdata_i,
    input  logic [NumReq*Mw-1:0]     wmask_i,
    output logic [NumReq-1:0]        rvalid_o,
    output logic [Width-1:0]         rdata_o,
    output logic                     rerr_o,
    input  logic                     clear_i,
    output logic                     init_busy_o
);

    localparam logic [Aw-1:0] LastIdx = Aw'(Depth - 1);

    typedef struct packed {
        logic             write;
        logic [Aw-1:0]    addr;
        logic [Width-1:0] wdata;
        logic [Mw-1:0]    wmask;
    } table_req_t;

    table_req_t        req_bus [NumReq];
    table_req_t        sel_req;
    TableInitState     state_reg;
    TableInitState     state_next;
    logic [Aw-1:0]     cnt_reg;
    logic [Aw-1:0]     cnt_next;
    logic              arb_en;
    logic              addr_ok;
    logic              acc_fire;
    logic              rd_fire;
    logic              mem_we;
    logic [Aw-1:0]     mem_waddr;
    logic [Width-1:0]  mem_wdata;
    logic [Mw-1:0]     mem_wmask;
    logic [Width-1:0]  mem [Depth];
    logic [NumReq-1:0] rvalid1_reg;
    logic              rerr1_reg;
    logic [Width-1:0]  rdata1_reg;

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
            assign req_bus[gi] = {write_i[gi], addr_i[gi*Aw +: Aw],
                                  wdata_i[gi*Width +: Width], wmask_i[gi*Mw +: Mw]};
        end
    endgenerate

    i3c_rr_arbiter #(
        .NumReq (NumReq)
    ) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (arb_en),
        .req_i  (req_i),
        .gnt_o  (gnt_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The counter only runs in INIT and always restarts from zero.
    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        case (state_reg)
            INIT: begin
                if (cnt_reg == LastIdx) begin
                    state_next = READY;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            READY: begin
                if (clear_i) begin
                    state_next = INIT;
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        init_busy_o = (state_reg == INIT);
        arb_en      = (state_reg == READY);
    end

    always_comb begin
        sel_req = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (gnt_o[k]) begin
                sel_req = req_bus[k];
            end
        end
    end

    // Power-of-two tables cannot be addressed out of range.
    generate
        if (Depth == (1 << Aw)) begin : g_full_range
            assign addr_ok = 1'b1;
        end else begin : g_partial_range
            assign addr_ok = ({1'b0, sel_req.addr} < (Aw + 1)'(Depth));
        end
    endgenerate

    always_comb begin
        acc_fire = |gnt_o;
        rd_fire  = acc_fire && !sel_req.write;
        if (init_busy_o) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_reg;
            mem_wdata = '0;
            mem_wmask = '1;
        end else begin
            mem_we    = acc_fire && sel_req.write && addr_ok;
            mem_waddr = sel_req.addr;
            mem_wdata = sel_req.wdata;
            mem_wmask = sel_req.wmask;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int l = 0; l < Mw; l++) begin
                if (mem_wmask[l]) begin
                    mem[mem_waddr][l*DataBitsPerMask +: DataBitsPerMask] <=
                        mem_wdata[l*DataBitsPerMask +: DataBitsPerMask];
                end
            end
        end
    end

    // Read data is captured before the same edge's write lands, and holds between reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid1_reg <= '0;
            rerr1_reg   <= 1'b0;
            rdata1_reg  <= '0;
        end else begin
            rvalid1_reg <= rd_fire ? gnt_o : '0;
            rerr1_reg   <= rd_fire && !addr_ok;
            if (rd_fire) begin
                rdata1_reg <= addr_ok ? mem[sel_req.addr] : '0;
            end
        end
    end

    generate
        if (OutputReg != 0) begin : g_out_reg
            logic [NumReq-1:0] rvalid2_reg;
            logic              rerr2_reg;
            logic [Width-1:0]  rdata2_reg;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rvalid2_reg <= '0;
                    rerr2_reg   <= 1'b0;
                    rdata2_reg  <= '0;
                end else begin
                    rvalid2_reg <= rvalid1_reg;
                    rerr2_reg   <= rerr1_reg;
                    if (|rvalid1_reg) begin
                        rdata2_reg <= rdata1_reg;
                    end
                end
            end

            assign rvalid_o = rvalid2_reg;
            assign rerr_o   = rerr2_reg;
            assign rdata_o  = rdata2_reg;
        end else begin : g_no_out_reg
            assign rvalid_o = rvalid1_reg;
            assign rerr_o   = rerr1_reg;
            assign rdata_o  = rdata1_reg;
        end
    endgenerate

endmodule

// File: tb/tb_i3c_table_ram.sv
// Bench for i3c_table_ram: a 6-entry 3-requester instance under a per-cycle model,
// plus an 8-entry single-requester instance with the output register.
module tb_i3c_table_ram;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    // Instance A: Depth 6, NumReq 3, no output register
    logic [2:0]   req_a    = '0;
    logic [2:0]   write_a  = '0;
    logic [8:0]   addr_a   = '0;
    logic [191:0] wdata_a  = '0;
    logic [5:0]   wmask_a  = '0;
    logic         clear_a  = 1'b0;
    logic [2:0]   gnt_a;
    logic [2:0]   rvalid_a;
    logic [63:0]  rdata_a;
    logic         rerr_a;
    logic         busy_a;

    i3c_table_ram #(
        .Depth (6), .Width (64), .DataBitsPerMask (32), .NumReq (3), .OutputReg (0)
    ) dut_a (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req_a),
        .gnt_o       (gnt_a),
        .write_i     (write_a),
        .addr_i      (addr_a),
        .wdata_i     (wdata_a),
        .wmask_i     (wmask_a),
        .rvalid_o    (rvalid_a),
        .rdata_o     (rdata_a),
        .rerr_o      (rerr_a),
        .clear_i     (clear_a),
        .init_busy_o (busy_a)
    );

    // Instance B: Depth 8, NumReq 1, registered output
    logic [0:0]  req_b   = '0;
    logic [0:0]  write_b = '0;
    logic [2:0]  addr_b  = '0;
    logic [63:0] wdata_b = '0;
    logic [1:0]  wmask_b = '0;
    logic [0:0]  gnt_b;
    logic [0:0]  rvalid_b;
    logic [63:0] rdata_b;
    logic        rerr_b;
    logic        busy_b;

    i3c_table_ram #(
        .Depth (8), .Width (64), .DataBitsPerMask (32), .NumReq (1), .OutputReg (1)
    ) dut_b (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req_b),
        .gnt_o       (gnt_b),
        .write_i     (write_b),
        .addr_i      (addr_b),
        .wdata_i     (wdata_b),
        .wmask_i     (wmask_b),
        .rvalid_o    (rvalid_b),
        .rdata_o     (rdata_b),
        .rerr_o      (rerr_b),
        .clear_i     (1'b0),
        .init_busy_o (busy_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'h1111_1111_1111_1111 * 64'(i + 1);
    endfunction

    // Model of instance A: table contents, remaining clear cycles, round-robin turn
    logic [63:0] mdl_mem [6];
    int          busy_left  = 6;
    int          turn       = 0;
    logic [2:0]  exp_rvalid = '0;
    logic        exp_rerr   = 1'b0;
    logic [63:0] exp_rdata  = '0;

    always @(negedge clk) begin : model_cmp
        logic [2:0]  eg;
        logic [2:0]  nv;
        logic        nerr;
        logic [63:0] ndata;
        int          k;
        int          a;
        if (!rst_n) begin
            chk("rst_gnt", 64'(gnt_a), 64'd0);
            chk("rst_busy", 64'(busy_a), 64'd1);
            chk("rst_rvalid", 64'(rvalid_a), 64'd0);
            chk("rst_rdata", rdata_a, 64'd0);
            chk("rst_rerr", 64'(rerr_a), 64'd0);
            busy_left  = 6;
            turn       = 0;
            exp_rvalid = '0;
            exp_rerr   = 1'b0;
            exp_rdata  = '0;
            for (int i = 0; i < 6; i++) mdl_mem[i] = '0;
        end else begin
            eg = '0;
            k  = -1;
            if (busy_left == 0) begin
                for (int off = 0; off < 3; off++) begin
                    if (k < 0 && req_a[(turn + off) % 3]) k = (turn + off) % 3;
                end
            end
            if (k >= 0) eg[k] = 1'b1;
            chk("gnt", 64'(gnt_a), 64'(eg));
            chk("busy", 64'(busy_a), 64'(busy_left != 0));
            chk("rvalid", 64'(rvalid_a), 64'(exp_rvalid));
            chk("rdata", rdata_a, exp_rdata);
            chk("rerr", 64'(rerr_a), 64'(exp_rerr));
            nv    = '0;
            nerr  = 1'b0;
            ndata = exp_rdata;
            if (busy_left > 0) begin
                busy_left--;
            end else begin
                if (k >= 0) begin
                    a    = int'(addr_a[k*3 +: 3]);
                    turn = (k + 1) % 3;
                    if (write_a[k]) begin
                        if (a < 6) begin
                            for (int l = 0; l < 2; l++) begin
                                if (wmask_a[k*2 + l]) mdl_mem[a][l*32 +: 32] = wdata_a[k*64 + l*32 +: 32];
                            end
                        end
                    end else begin
                        nv[k] = 1'b1;
                        nerr  = (a >= 6);
                        ndata = (a < 6) ? mdl_mem[a] : 64'd0;
                    end
                    $display("[TB] A grant req%0d %s addr=%0d", k, write_a[k] ? "wr" : "rd", a);
                end
                if (clear_a) begin
                    busy_left = 6;
                    for (int i = 0; i < 6; i++) mdl_mem[i] = '0;
                end
            end
            exp_rvalid = nv;
            exp_rerr   = nerr;
            exp_rdata  = ndata;
        end
    end

    task automatic access_a(input int k, input bit wr, input int a, input logic [63:0] d,
                            input logic [1:0] m);
        bit got = 1'b0;
        @(posedge clk); #1;
        req_a[k]            = 1'b1;
        write_a[k]          = wr;
        addr_a[k*3 +: 3]    = 3'(a);
        wdata_a[k*64 +: 64] = d;
        wmask_a[k*2 +: 2]   = m;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = gnt_a[k];
        end
        chk("a_grant_seen", 64'(got), 64'd1);
        @(posedge clk); #1;
        req_a[k] = 1'b0;
    endtask

    task automatic read_a(input int k, input int a, output logic [63:0] d, output logic e);
        bit got = 1'b0;
        int lat = 0;
        access_a(k, 1'b0, a, 64'd0, 2'b00);
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            lat++;
            got = rvalid_a[k];
        end
        if (!got) lat = -1;
        chk("a_read_latency", 64'(lat), 64'd1);
        d = rdata_a;
        e = rerr_a;
    endtask

    task automatic b_access(input bit wr, input logic [2:0] a, input logic [63:0] d,
                            input logic [1:0] m);
        bit got = 1'b0;
        @(posedge clk); #1;
        req_b   = 1'b1;
        write_b = wr;
        addr_b  = a;
        wdata_b = d;
        wmask_b = m;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = gnt_b[0];
        end
        chk("b_grant_seen", 64'(got), 64'd1);
        @(posedge clk); #1;
        req_b = 1'b0;
    endtask

    task automatic b_read(input logic [2:0] a, output logic [63:0] d, output logic e,
                          output int lat);
        bit got = 1'b0;
        b_access(1'b0, a, 64'd0, 2'b00);
        lat = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            lat++;
            got = rvalid_b[0];
        end
        if (!got) lat = -1;
        d = rdata_b;
        e = rerr_b;
        $display("[TB] B read addr=%0d data=%h err=%0b latency=%0d", a, d, e, lat);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [63:0] d;
        logic        e;
        int          lat;
        int          cnt_a;
        int          cnt_b;
        int          nbusy;
        logic [2:0]  rr_exp [6];
        logic [2:0]  rr_got;

        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        // Reset, then measure the clear-on-reset duration of both instances
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_a) cnt_a++;
            if (busy_b) cnt_b++;
        end
        chk("a_busy_after_reset", 64'(cnt_a), 64'd6);
        chk("b_busy_after_reset", 64'(cnt_b), 64'd8);

        // Instance B: cleared reads, masked writes, two-cycle read latency
        for (int i = 0; i < 8; i += 3) begin
            b_read(3'(i), d, e, lat);
            chk("b_cleared_data", d, 64'd0);
            chk("b_cleared_rerr", 64'(e), 64'd0);
        end
        b_access(1'b1, 3'd3, 64'hDEAD_BEEF_0123_4567, 2'b01);
        b_access(1'b1, 3'd3, 64'hFFFF_FFFF_AAAA_5555, 2'b10);
        b_read(3'd3, d, e, lat);
        chk("b_merged_data", d, 64'hFFFF_FFFF_0123_4567);
        chk("b_latency", 64'(lat), 64'd2);

        // Instance A: every entry reads zero after reset
        for (int i = 0; i < 6; i++) begin
            read_a(i % 3, i, d, e);
            chk("a_cleared_data", d, 64'd0);
            chk("a_cleared_rerr", 64'(e), 64'd0);
        end

        // Lane-masked writes merge into one entry
        access_a(0, 1'b1, 3, 64'hDEAD_BEEF_0123_4567, 2'b01);
        access_a(2, 1'b1, 3, 64'hFFFF_FFFF_9999_8888, 2'b10);
        chk("model_pin_addr3", mdl_mem[3], 64'hFFFF_FFFF_0123_4567);
        read_a(1, 3, d, e);
        chk("a_merged_data", d, 64'hFFFF_FFFF_0123_4567);
        access_a(0, 1'b1, 3, 64'h0, 2'b00);
        read_a(0, 3, d, e);
        chk("a_zero_mask_keeps", d, 64'hFFFF_FFFF_0123_4567);

        // Round robin with all three requesters held; a grant to 2 first resets the turn
        access_a(2, 1'b0, 0, 64'd0, 2'b00);
        @(posedge clk); #1;
        write_a = 3'b000;
        addr_a  = {3'd2, 3'd1, 3'd0};
        req_a   = 3'b111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rr_got = gnt_a;
            chk("rr_sequence", 64'(rr_got), 64'(rr_exp[i]));
        end
        @(posedge clk); #1;
        req_a = 3'b000;

        // Out-of-range read and write
        read_a(0, 7, d, e);
        chk("oor_read_data", d, 64'd0);
        chk("oor_read_rerr", 64'(e), 64'd1);
        for (int i = 0; i < 6; i++) access_a(i % 3, 1'b1, i, pat(i), 2'b11);
        access_a(1, 1'b1, 7, 64'hBAD0_BAD0_BAD0_BAD0, 2'b11);
        for (int i = 0; i < 6; i++) begin
            read_a((i + 1) % 3, i, d, e);
            chk("oor_write_untouched", d, pat(i));
        end

        // Software clear with a read granted on the clear cycle and a request held through it
        @(posedge clk); #1;
        req_a      = 3'b001;
        write_a[0] = 1'b0;
        addr_a[2:0] = 3'd2;
        clear_a    = 1'b1;
        @(negedge clk);
        chk("clr_cycle_gnt", 64'(gnt_a), 64'b001);
        @(posedge clk); #1;
        clear_a     = 1'b0;
        req_a       = 3'b010;
        write_a[1]  = 1'b0;
        addr_a[5:3] = 3'd4;
        @(negedge clk);
        chk("clr_old_rvalid", 64'(rvalid_a), 64'b001);
        chk("clr_old_rdata", rdata_a, pat(2));
        nbusy = 0;
        for (int i = 0; i < 20 && busy_a; i++) begin
            nbusy++;
            chk("clr_gnt_blocked", 64'(gnt_a), 64'd0);
            @(negedge clk);
        end
        chk("clr_busy_cycles", 64'(nbusy), 64'd6);
        chk("clr_gnt_after", 64'(gnt_a), 64'b010);
        @(posedge clk); #1;
        req_a = 3'b000;
        @(negedge clk);
        chk("clr_read_rvalid", 64'(rvalid_a), 64'b010);
        chk("clr_read_rdata", rdata_a, 64'd0);
        for (int i = 0; i < 6; i++) begin
            read_a(i % 3, i, d, e);
            chk("clr_entry_zero", d, 64'd0);
        end

        // Reset asserted while the clear counter is at 4
        @(posedge clk); #1 clear_a = 1'b1;
        @(posedge clk); #1 clear_a = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_a) cnt_a++;
        end
        chk("a_busy_after_midinit_reset", 64'(cnt_a), 64'd6);
        read_a(2, 5, d, e);
        chk("a_after_midinit_reset_data", d, 64'd0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/i3c_table_ram.md
# i3c_table_ram

Parametrised, multi-requester table memory for the I3C controller's address/characteristic tables (DAT, DCT and future per-target tables). It replaces the fixed two-instance single-port RAM arrangement at the top level with one generic block. The block adds:
- hardware clear-on-reset and software-triggered clear;
- round-robin arbitration between NumReq requesters;
- a configurable read pipeline;
- out-of-range address detection.

## Interface
Parameters:
- Depth, 128, number of entries (any value ≥ 2; power of two not required)
- Width, 64, entry width in bits
- DataBitsPerMask, 32, bits per write-mask lane; Width must be a multiple
- NumReq, 2, number of requester ports (1..4)
- OutputReg, 0, 1 adds a registered read-data stage (read latency 2 instead of 1)

Ports (Aw = max(1, $clog2(Depth)), Mw = Width/DataBitsPerMask):
- clk_i  in  1  clock; the single clock of the block
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NumReq  per-requester access request, held until granted
- gnt_o  out  NumReq  one-hot grant, combinational, same cycle
- write_i  in  NumReq  1 = write, 0 = read
- addr_i  in  NumReq×Aw  entry index
- wdata_i  in  NumReq×Width  write data
- wmask_i  in  NumReq×Mw  per-lane write enable
- rvalid_o  out  NumReq  read data valid for that requester
- rdata_o  out  Width  shared read data, qualified by rvalid_o
- rerr_o  out  1  out-of-range read flag, coincident with rvalid_o
- clear_i  in  1  single-cycle pulse that requests a clear of all entries
- init_busy_o  out  1  clear sequence in progress

## Operation
- FSM states:
  - INIT: on leaving reset, the block enters INIT with counter = 0. It writes all-zero with a full mask to entry counter on each cycle, then increments. At counter == Depth-1 (that write included) it moves to READY.
  - READY: gnt_o is enabled. A clear_i pulse moves the FSM to INIT on the next cycle, with counter = 0.
- clear_i is ignored while in INIT; no re-queue and no restart.
- gnt_o = 0 throughout INIT. Requests stay pending.
- Arbitration: round-robin.
  - Pointer ptr resets to 0.
  - The grant goes to the first asserted req_i at or after ptr, searching modulo NumReq.
  - After a grant to k, ptr ← (k+1) mod NumReq.
  - At most one grant per cycle.
- Writes: on the grant cycle, lanes with wmask set are updated at the next edge. If wmask = 0 the access is granted but nothing is updated.
- Reads: rvalid_o[k] pulses L = 1+OutputReg cycles after the grant to k. rdata_o holds the entry value as of the grant cycle; a write granted in the same cycle is impossible, since there is one port.
- Out-of-range (addr ≥ Depth):
  - A write is granted and discarded.
  - A read is granted and returns rdata_o = 0 with rerr_o = 1 alongside rvalid_o.
- The read pipeline keeps draining across an INIT entry. Reads granted before the clear return their pre-clear data.
- When rvalid_o is low, rdata_o holds its last value. It is not forced to zero.

## Timing
- Reset values:
  - gnt_o = 0, rvalid_o = 0, rerr_o = 0, rdata_o = 0.
  - init_busy_o = 1 (INIT is entered directly from reset).
- Clear duration: init_busy_o is high for exactly Depth cycles after reset deassertion, or after the cycle following clear_i.
- Throughput: one access per cycle in READY. Back-to-back reads from one requester are allowed once that requester is the only one asserting req_i.
- Asynchronous reset mid-INIT or mid-read:
  - all state resets, including the in-flight rvalid pipeline;
  - INIT restarts from 0.
- No combinational path from req_i to rdata_o or rvalid_o.

## Structure
- Shared package i3c_pkg:
  - typedef i3c_table_req_t (write, addr, wdata, wmask), parametrised via localparams;
  - TableInitState enum {INIT, READY}.
- One natural sub-module: i3c_rr_arbiter (NumReq, req → one-hot gnt and ptr update). It is reusable by the controller's queue muxes.
- Storage is an internal register array; no vendor macro.

## Test plan
- Reset with Depth=8, Width=64:
  - init_busy_o is high for 8 cycles;
  - every read afterwards returns 0 with rerr_o = 0.
- Write addr 3 = 0xDEAD_BEEF_0123_4567 with wmask = 2'b01, then write wmask = 2'b10 with data 0xFFFF_FFFF_xxxx_xxxx → read addr 3 = 0xFFFF_FFFF_0123_4567, rvalid one cycle after grant. With OutputReg=1, rvalid comes two cycles after grant.
- NumReq=3, all three req_i held → grants 0,1,2,0,1,2 on consecutive cycles.
- Depth=6, read addr 7 → rvalid with rdata = 0 and rerr_o = 1. A write to addr 7 leaves entries 0–5 unchanged.
- Fill entries with nonzero data, then:
  - pulse clear_i → six busy cycles with gnt_o = 0 while req_i is held;
  - afterwards all reads return 0;
  - a read granted on the cycle of clear_i returns the old data.
- Assert rst_ni low mid-INIT at counter = 4 → after release, full INIT of Depth cycles, with outputs at reset values during reset.
